// File: rtl/ksa_add_scheduler.sv
// ksa_add_scheduler: shares one external combinational 32-bit Kogge-Stone
// adder between two requesters. Narrow (32-bit) ops take one adder pass and
// wide (64-bit) ops take two chained passes. Grants are round-robin, and
// results return on a single response channel tagged with the owner's id.
module ksa_add_scheduler #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_wide,
    input  logic [4*W-1:0]   req_a,
    input  logic [4*W-1:0]   req_b,
    input  logic [1:0]       req_cin,
    output logic [W-1:0]     ksa_a,
    output logic [W-1:0]     ksa_b,
    output logic             ksa_cin,
    input  logic [W-1:0]     ksa_sum,
    input  logic             ksa_cout,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [2*W-1:0]   resp_sum,
    output logic             resp_cout,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC_LO = 2'd1,
        EXEC_HI = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t         state;

    // Operation registers, latched on accept so requesters may move on.
    logic [2*W-1:0] a_q;
    logic [2*W-1:0] b_q;
    logic           cin_q;
    logic           wide_q;
    logic           id_q;

    // Result registers.
    logic [W-1:0]   sum_lo;
    logic [W-1:0]   sum_hi;
    logic           c_mid;
    logic           cout_q;

    // Round-robin pointer: the requester that completed most recently.
    logic           last_grant;

    // Arbitration outcome for the current IDLE cycle.
    logic           grant_any;
    logic           grant_id;

    // Round-robin arbitration; only meaningful in IDLE and suppressed in reset.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        grant_any = 1'b0;
        grant_id  = 1'b0;
        // Gating with rst_n keeps req_ready low while reset is held, so no
        // requester sees an accept that the FSM cannot act on.
        if (state == IDLE && rst_n) begin
            case (req_valid)
                2'b01: begin
                    grant_any = 1'b1;
                    grant_id  = 1'b0;
                end
                2'b10: begin
                    grant_any = 1'b1;
                    grant_id  = 1'b1;
                end
                2'b11: begin
                    grant_any = 1'b1;
                    grant_id  = ~last_grant;
                end
                default: begin
                    grant_any = 1'b0;
                    grant_id  = 1'b0;
                end
            endcase
        end
        req_ready = grant_any ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    end

    // Adder operand drive: low half then high half chained through c_mid.
    always_comb begin
        ksa_a   = '0;
        ksa_b   = '0;
        ksa_cin = 1'b0;
        case (state)
            EXEC_LO: begin
                ksa_a   = a_q[W-1:0];
                ksa_b   = b_q[W-1:0];
                ksa_cin = cin_q;
            end
            EXEC_HI: begin
                ksa_a   = a_q[2*W-1:W];
                ksa_b   = b_q[2*W-1:W];
                ksa_cin = c_mid;
            end
            default: begin
                ksa_a   = '0;
                ksa_b   = '0;
                ksa_cin = 1'b0;
            end
        endcase
    end

    // Sequencer: accept, one or two adder passes, then hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            wide_q     <= 1'b0;
            id_q       <= 1'b0;
            sum_lo     <= '0;
            sum_hi     <= '0;
            c_mid      <= 1'b0;
            cout_q     <= 1'b0;
            last_grant <= 1'b1;
            ops_done   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        a_q    <= grant_id ? req_a[4*W-1:2*W] : req_a[2*W-1:0];
                        b_q    <= grant_id ? req_b[4*W-1:2*W] : req_b[2*W-1:0];
                        cin_q  <= req_cin[grant_id];
                        wide_q <= req_wide[grant_id];
                        id_q   <= grant_id;
                        // Narrow ops report a zero upper half.
                        sum_hi <= '0;
                        state  <= EXEC_LO;
                    end
                end
                EXEC_LO: begin
                    sum_lo <= ksa_sum;
                    c_mid  <= ksa_cout;
                    state  <= wide_q ? EXEC_HI : RESP;
                end
                EXEC_HI: begin
                    sum_hi <= ksa_sum;
                    cout_q <= ksa_cout;
                    state  <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        last_grant <= id_q;
                        ops_done   <= ops_done + CNT_W'(1);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response fields come straight from registers and read as zero outside RESP.
    assign resp_valid = (state == RESP);
    assign resp_id    = resp_valid & id_q;
    assign resp_sum   = resp_valid ? {sum_hi, sum_lo} : '0;
    assign resp_cout  = resp_valid & (wide_q ? cout_q : c_mid);
    assign busy       = (state != IDLE);

endmodule

// File: doc/ksa_add_scheduler.md
Name: ksa_add_scheduler

Overview:
- Sequencer and arbiter that shares one external 32-bit Kogge-Stone adder datapath between two requesters.
- Each requester submits 32-bit (narrow) or 64-bit (wide) add operations over a valid/ready handshake.
- Operations are granted round-robin. Each operation is issued to the adder in one pass (narrow) or two chained passes (wide: low half, then high half).
- Results are returned on a shared response channel tagged with the requester id.
- The adder is combinational. The block drives its operands and registers its sum and carry-out every cycle.

Parameters:
- W, 32, width of one adder pass. Fixed at 32 to match the adder; wide ops are 2*W.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- req_ready  output  2  per-requester accept.
- req_wide  input  2  per-requester op size: 1 = 64-bit, 0 = 32-bit.
- req_a  input  128  operand A; requester i uses [64i+63:64i].
- req_b  input  128  operand B, same packing as req_a.
- req_cin  input  2  per-requester carry-in.
- ksa_a  output  32  adder operand A.
- ksa_b  output  32  adder operand B.
- ksa_cin  output  1  adder carry-in.
- ksa_sum  input  32  adder sum, combinational from ksa_a/ksa_b/ksa_cin.
- ksa_cout  input  1  adder carry-out of bit 31.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_id  output  1  requester that owns the result.
- resp_sum  output  64  result; upper 32 bits are 0 for narrow ops.
- resp_cout  output  1  final carry-out.
- busy  output  1  high whenever state is not IDLE.
- ops_done  output  CNT_W  count of completed response handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous assert, synchronous-release use): state = IDLE, last_grant = 1, all outputs 0, ops_done = 0.
- Reset mid-operation: the in-flight op is abandoned and no response is produced.
- FSM states: IDLE, EXEC_LO, EXEC_HI, RESP.
- IDLE, arbitration:
  - req_ready is combinational and only asserted in IDLE; at most one bit is high.
  - One requester valid: it wins.
  - Both valid: the requester != last_grant wins.
- IDLE, on accept (req_valid[g] & req_ready[g]): latch a, b, cin, wide and g into internal registers; go to EXEC_LO.
- Latched data: requesters may change inputs freely after accept.
- EXEC_LO:
  - Drive ksa_a = a[31:0], ksa_b = b[31:0], ksa_cin = cin.
  - At clock edge, register sum_lo = ksa_sum and c_mid = ksa_cout.
  - If wide, go to EXEC_HI; else go to RESP.
- EXEC_HI:
  - Drive ksa_a = a[63:32], ksa_b = b[63:32], ksa_cin = c_mid.
  - At clock edge, register sum_hi = ksa_sum and cout = ksa_cout; go to RESP.
- Narrow op result: sum_hi = 0, resp_cout = c_mid.
- ksa_a, ksa_b, ksa_cin are 0 in IDLE and RESP.
- RESP:
  - resp_valid = 1; resp_id, resp_sum, resp_cout are held stable until resp_ready.
  - On handshake: last_grant = id, ops_done increments, go to IDLE.
- Latency, counting the accept edge as T:
  - Narrow ops: resp_valid high from after edge T+1.
  - Wide ops: resp_valid high from after edge T+2.
- Minimum initiation interval, with resp_ready held high: narrow 3 cycles, wide 4 cycles. The IDLE cycle is mandatory.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1,...
- A requester dropping valid before grant is legal (no accept occurs); valid need not be sticky.
- Backpressure: resp_ready low stalls the FSM in RESP indefinitely; no new request is accepted meanwhile.
- ops_done wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset, then requester 0 issues a narrow op: a=0xFFFFFFFF, b=0x00000001, cin=0. Required: resp_sum=0x0000000000000000, resp_cout=1, resp_id=0, resp_valid 2 cycles after accept, ops_done=1.
- Requester 1 issues a wide op: a=0x00000000FFFFFFFF, b=1, cin=0. Required: high pass sees ksa_cin=1, resp_sum=0x0000000100000000, resp_cout=0, resp_id=1, resp_valid 3 cycles after accept.
- Wide op a=0xFFFFFFFFFFFFFFFF, b=0, cin=1. Required: resp_sum=0, resp_cout=1.
- Both requesters valid continuously for 6 ops with resp_ready=1. Required: grant order 0,1,0,1,0,1; a narrow op accepted every 3 cycles; req_ready never has both bits set.
- Hold resp_ready=0 for 5 cycles in RESP while req_valid=2'b11. Required: resp outputs stable, req_ready=0, busy=1; completion occurs one cycle after resp_ready rises.
- Assert rst_n=0 during EXEC_HI of a wide op. Required: all outputs 0 immediately, no response, next op starts cleanly with requester 0 winning the tie.
